// File: rtl/mux_sel_pkg.sv
// Shared constants, FSM state type and round-robin pick helper for the 8:1 channel mux scheduler.
package mux_sel_pkg;

  localparam int NCH = 8;
  localparam int SW  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic          found;
    logic [SW-1:0] idx;
  } pick_t;

  // First set bit of req searching start, start+1, ... modulo NCH.
  function automatic pick_t rr_pick(input logic [NCH-1:0] req, input logic [SW-1:0] start);
    pick_t         res;
    logic [SW-1:0] k;
    res = '{found: 1'b0, idx: {SW{1'b0}}};
    for (int i = NCH - 1; i >= 0; i--) begin
      k = start + i[SW-1:0];
      if (req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin finder: the channel after 'last' has highest priority, 'last' itself lowest.
module rr_pick_comb
  import mux_sel_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  last,
  output logic           found,
  output logic [SW-1:0]  idx
);

  logic [SW-1:0]    first_s;
  logic [2*NCH-1:0] dbl_s;
  logic [NCH-1:0]   rot_s;
  logic [SW-1:0]    off_s;

  assign first_s = last + {{(SW-1){1'b0}}, 1'b1};
  assign dbl_s   = {req, req};
  assign rot_s   = dbl_s[first_s +: NCH];

  // Priority-encode the rotated vector; lowest offset wins.
  always_comb begin
    off_s = {SW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = i[SW-1:0];
      end else begin
        off_s = off_s;
      end
    end
  end

  assign found = |rot_s;
  assign idx   = first_s + off_s;

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin grant scheduler driving the 8:1 channel mux select and a matching one-hot grant.
// Optional forced release after TIMEOUT_CYC held cycles when MUX_SEL_TIMEOUT_EN is defined.
module mux_sel_scheduler
  import mux_sel_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           done,
  output logic [SW-1:0]  sel,
  output logic [NCH-1:0] grant,
  output logic           busy,
  output logic           timeout
);

  state_e         state_r, state_s;
  logic [SW-1:0]  ptr_r, ptr_s;
  logic [SW-1:0]  sel_r, sel_s;
  logic [NCH-1:0] grant_r, grant_s;
  logic           busy_r, busy_s;
  logic           timeout_r, timeout_s;
  logic [SW-1:0]  base_s, pick_idx_s;
  logic           pick_found_s, release_s, to_fire_s;

  // While busy the current channel is searched last; while idle the last-served one is.
  assign base_s    = (state_r == BUSY) ? sel_r : ptr_r;
  assign release_s = (state_r == BUSY) && (done || to_fire_s);

  rr_pick_comb u_pick (
    .req   (req),
    .last  (base_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

`ifdef MUX_SEL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] hold_r, hold_s;

  // done in the same cycle takes precedence, so the timeout never fires alongside it.
  assign to_fire_s = (state_r == BUSY) && !done && (hold_r == CW'(TIMEOUT_CYC - 1));

  // Hold counter: cleared on every new grant, counts held cycles otherwise.
  always_comb begin
    if ((state_r == IDLE) || release_s) begin
      hold_s = {CW{1'b0}};
    end else begin
      hold_s = hold_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= {CW{1'b0}};
    end else begin
      hold_r <= hold_s;
    end
  end
`else
  assign to_fire_s = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= SW'(NCH - 1);
      sel_r     <= {SW{1'b0}};
      grant_r   <= {NCH{1'b0}};
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      sel_r     <= sel_s;
      grant_r   <= grant_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) state_s = BUSY;
        else              state_s = IDLE;
      end
      BUSY: begin
        if (release_s && !pick_found_s) state_s = IDLE;
        else                            state_s = BUSY;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the last-served pointer.
  always_comb begin
    ptr_s     = ptr_r;
    sel_s     = sel_r;
    grant_s   = grant_r;
    busy_s    = busy_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          sel_s   = pick_idx_s;
          grant_s = {{(NCH-1){1'b0}}, 1'b1} << pick_idx_s;
          busy_s  = 1'b1;
        end else begin
          grant_s = {NCH{1'b0}};
          busy_s  = 1'b0;
        end
      end
      BUSY: begin
        if (release_s) begin
          ptr_s     = sel_r;
          timeout_s = to_fire_s;
          if (pick_found_s) begin
            sel_s   = pick_idx_s;
            grant_s = {{(NCH-1){1'b0}}, 1'b1} << pick_idx_s;
            busy_s  = 1'b1;
          end else begin
            grant_s = {NCH{1'b0}};
            busy_s  = 1'b0;
          end
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        grant_s = {NCH{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  assign sel     = sel_r;
  assign grant   = grant_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule
